// File: rtl/serial_pkg.sv
// Shared definitions for the serializer and the downstream "101" detector.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int unsigned SER_WIDTH_DEFAULT = 8;
  localparam logic [2:0]  DETECT_PATTERN    = 3'b101;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage: takes WIDTH-bit words over valid/ready and
// emits them one bit per clock, with zero-gap back-to-back streaming.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = SER_WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_last
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   sreg_q,  sreg_d;
  logic               last_c;
  logic               xfer_c;
  logic [WIDTH-1:0]   sreg_adv_c;

  assign last_c = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  assign xfer_c = load_valid && load_ready;

  // Advance toward the output end, zero-filling the vacated side.
  assign sreg_adv_c = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, sreg_q[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_c) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sreg_d  = load_data;
        end
      end
      ST_SHIFT: begin
        if (!last_c) begin
          cnt_d  = cnt_q + CNT_W'(1);
          sreg_d = sreg_adv_c;
        end else if (xfer_c) begin
          cnt_d  = '0;
          sreg_d = load_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state only; load_ready never sees load_valid.
  always_comb begin
    load_ready  = 1'b0;
    ser_out     = IDLE_BIT;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    frame_last  = 1'b0;
    if (state_q == ST_IDLE) begin
      load_ready = 1'b1;
    end else begin
      load_ready  = last_c;
      ser_out     = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
      ser_valid   = 1'b1;
      frame_start = (cnt_q == '0);
      frame_last  = last_c;
    end
  end

endmodule
